// File: rtl/cvrx_pkg.sv
// rtl/cvrx_pkg.sv - shared types and constants for the clocked video receiver
package cvrx_pkg;

  // Avalon-ST Video packet type nibbles
  localparam logic [3:0] CVRX_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] CVRX_TYPE_CTRL  = 4'hF;

  typedef enum logic [1:0] {
    CVRX_IDLE   = 2'd0,
    CVRX_HDR    = 2'd1,
    CVRX_ACTIVE = 2'd2,
    CVRX_DROP   = 2'd3
  } cvrx_state_t;

  // One stream beat as stored in the output FIFO (26 bits)
  typedef struct packed {
    logic [23:0] data;
    logic        sop;
    logic        eop;
  } cvrx_beat_t;

  // Increment that sticks at lim instead of wrapping
  function automatic logic [11:0] cvrx_sat_inc(input logic [11:0] v, input logic [11:0] lim);
    return (v >= lim) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/cvrx_fifo.sv
// rtl/cvrx_fifo.sv - synchronous show-ahead FIFO of stream beats with occupancy count
module cvrx_fifo
  import cvrx_pkg::*;
#(
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_tvalid,
  input  cvrx_beat_t wr_tdata,
  output logic       rd_tvalid,
  output cvrx_beat_t rd_tdata,
  input  logic       rd_tready,
  output logic [AW:0] count
);

  cvrx_beat_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic rd_fire;
  logic wr_fire;

  assign rd_tvalid = (count != '0);
  assign rd_fire   = rd_tvalid & rd_tready;
  // A read in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_fire   = wr_tvalid & ((count != (AW+1)'(DEPTH)) | rd_fire);
  assign rd_tdata  = mem[rd_ptr];

  // Storage array; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_tdata;
  end

  // Pointers and occupancy; reset flushes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/clocked_video_rx.sv
// rtl/clocked_video_rx.sv - clocked video to Avalon-ST Video receiver; control packets enabled by CVRX_CTRL_PKT_EN
module clocked_video_rx
  import cvrx_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_DIM    = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] vid_data,
  input  logic        vid_datavalid,
  input  logic        vid_h_sync,
  input  logic        vid_v_sync,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_startofpacket,
  output logic        source_endofpacket,
  output logic        overflow,
  output logic [11:0] frame_width,
  output logic [11:0] frame_height
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [11:0] DIM_LIM = 12'(MAX_DIM - 1);

  localparam logic [1:0] ST_IDLE   = CVRX_IDLE;
  localparam logic [1:0] ST_HDR    = CVRX_HDR;
  localparam logic [1:0] ST_ACTIVE = CVRX_ACTIVE;
  localparam logic [1:0] ST_DROP   = CVRX_DROP;

  logic [23:0] pix_q;
  logic        dv_q, dv_qq, hs_q, hs_qq, vs_q, vs_qq;
  logic        boundary, dv_rise, dv_fall, hs_rise;

  logic [1:0]  state, state_d;
  logic [2:0]  hdr_idx, hdr_len;
  logic        have_held;
  logic [23:0] held_data;
  logic        push, ovf_set, hold_load, hold_clr, idx_inc;
  cvrx_beat_t  push_beat, hdr_beat, head;
  logic        fifo_valid;
  logic [CW-1:0] fifo_count, fifo_free;

  logic [11:0] wcnt, hcnt;
  logic        first_line_done, line_armed;

  // Register every video input once; keep one more stage of the qualifiers for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q <= '0;
      dv_q  <= 1'b0;
      dv_qq <= 1'b0;
      hs_q  <= 1'b0;
      hs_qq <= 1'b0;
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
    end else begin
      pix_q <= vid_data;
      dv_q  <= vid_datavalid;
      dv_qq <= dv_q;
      hs_q  <= vid_h_sync;
      hs_qq <= hs_q;
      vs_q  <= vid_v_sync;
      vs_qq <= vs_q;
    end
  end

  assign boundary = vs_qq & ~vs_q;
  assign dv_rise  = dv_q & ~dv_qq;
  assign dv_fall  = ~dv_q & dv_qq;
  assign hs_rise  = hs_q & ~hs_qq;

  assign fifo_free = CW'(FIFO_DEPTH) - fifo_count;

`ifdef CVRX_CTRL_PKT_EN
  logic ctrl_ok;
  assign ctrl_ok = (frame_width != '0) && (frame_height != '0);
  assign hdr_len = ctrl_ok ? 3'd5 : 3'd1;

  // Header sequence: control packet (previous frame's W/H in nibble lanes) then video header
  always_comb begin
    hdr_beat      = '0;
    hdr_beat.data = {20'h0, CVRX_TYPE_VIDEO};
    hdr_beat.sop  = 1'b1;
    if (ctrl_ok) begin
      case (hdr_idx)
        3'd0: hdr_beat.data = {20'h0, CVRX_TYPE_CTRL};
        3'd1: begin
          hdr_beat.data = {4'h0, frame_width[7:4], 4'h0, frame_width[11:8], 4'h0, 4'h0};
          hdr_beat.sop  = 1'b0;
        end
        3'd2: begin
          hdr_beat.data = {4'h0, frame_height[11:8], 4'h0, 4'h0, 4'h0, frame_width[3:0]};
          hdr_beat.sop  = 1'b0;
        end
        3'd3: begin
          hdr_beat.data = {4'h0, 4'h0, 4'h0, frame_height[3:0], 4'h0, frame_height[7:4]};
          hdr_beat.sop  = 1'b0;
          hdr_beat.eop  = 1'b1;
        end
        default: hdr_beat.data = {20'h0, CVRX_TYPE_VIDEO};
      endcase
    end
  end
`else
  assign hdr_len = 3'd1;

  // Video packet header only
  always_comb begin
    hdr_beat      = '0;
    hdr_beat.data = {20'h0, CVRX_TYPE_VIDEO};
    hdr_beat.sop  = 1'b1;
  end
`endif

  // Next-state and FIFO write decode
  always_comb begin
    state_d   = state;
    push      = 1'b0;
    push_beat = '0;
    ovf_set   = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    idx_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (boundary) state_d = ST_HDR;
      end
      ST_HDR: begin
        // Keep one slot back beyond the header so the packet can always be closed
        if (hdr_idx == 3'd0 && fifo_free <= CW'(hdr_len)) begin
          state_d = ST_DROP;
          ovf_set = 1'b1;
        end else begin
          push      = 1'b1;
          push_beat = hdr_beat;
          if (hdr_idx == hdr_len - 3'd1) begin
            state_d  = ST_ACTIVE;
            hold_clr = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
        end
        if (dv_q) ovf_set = 1'b1;
      end
      ST_ACTIVE: begin
        if (boundary) begin
          push           = 1'b1;
          push_beat.data = have_held ? held_data : 24'h0;
          push_beat.eop  = 1'b1;
          hold_clr       = 1'b1;
          state_d        = ST_HDR;
        end else if (dv_q) begin
          if (!have_held) begin
            hold_load = 1'b1;
          end else if (fifo_count >= CW'(FIFO_DEPTH - 1)) begin
            push           = 1'b1;
            push_beat.data = held_data;
            push_beat.eop  = 1'b1;
            ovf_set        = 1'b1;
            hold_clr       = 1'b1;
            state_d        = ST_DROP;
          end else begin
            push           = 1'b1;
            push_beat.data = held_data;
            hold_load      = 1'b1;
          end
        end
      end
      default: begin
        if (boundary) state_d = ST_HDR;
      end
    endcase
  end

  // Control state, holding register and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hdr_idx   <= '0;
      have_held <= 1'b0;
      held_data <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_d;
      if (state != ST_HDR) hdr_idx <= '0;
      else if (idx_inc)    hdr_idx <= hdr_idx + 3'd1;
      if (hold_clr) begin
        have_held <= 1'b0;
      end else if (hold_load) begin
        have_held <= 1'b1;
        held_data <= pix_q;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // Frame measurement; a datavalid run only counts as a line once h_sync re-arms it
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt            <= '0;
      hcnt            <= '0;
      first_line_done <= 1'b0;
      line_armed      <= 1'b1;
      frame_width     <= '0;
      frame_height    <= '0;
    end else if (boundary) begin
      if (state != ST_IDLE) begin
        frame_width  <= wcnt;
        frame_height <= hcnt;
      end
      wcnt            <= '0;
      hcnt            <= '0;
      first_line_done <= 1'b0;
      line_armed      <= 1'b1;
    end else begin
      if (dv_q && !first_line_done) wcnt <= cvrx_sat_inc(wcnt, DIM_LIM);
      if (dv_fall) first_line_done <= 1'b1;
      if (dv_rise && (line_armed || hs_rise)) begin
        hcnt       <= cvrx_sat_inc(hcnt, DIM_LIM);
        line_armed <= 1'b0;
      end else if (hs_rise) begin
        line_armed <= 1'b1;
      end
    end
  end

  cvrx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_tvalid (push),
    .wr_tdata  (push_beat),
    .rd_tvalid (fifo_valid),
    .rd_tdata  (head),
    .rd_tready (source_ready),
    .count     (fifo_count)
  );

  assign source_valid         = fifo_valid;
  assign source_data          = fifo_valid ? head.data : 24'h0;
  assign source_startofpacket = fifo_valid & head.sop;
  assign source_endofpacket   = fifo_valid & head.eop;

endmodule

// File: tb/tb_clocked_video_rx.sv
// tb/tb_clocked_video_rx.sv - directed self-checking bench for clocked_video_rx
module tb_clocked_video_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] vid_data;
  logic        vid_datavalid;
  logic        vid_h_sync;
  logic        vid_v_sync;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_startofpacket;
  logic        source_endofpacket;
  logic        overflow;
  logic [11:0] frame_width;
  logic [11:0] frame_height;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 1;
  logic [25:0] rx_q[$];
  logic [25:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [25:0] prev_beat = '0;
  logic [25:0] mon_beat;

  always #5 clk = ~clk;

  clocked_video_rx #(.FIFO_DEPTH(64), .MAX_DIM(2048)) dut (
    .clk                  (clk),
    .reset                (reset),
    .vid_data             (vid_data),
    .vid_datavalid        (vid_datavalid),
    .vid_h_sync           (vid_h_sync),
    .vid_v_sync           (vid_v_sync),
    .source_data          (source_data),
    .source_valid         (source_valid),
    .source_ready         (source_ready),
    .source_startofpacket (source_startofpacket),
    .source_endofpacket   (source_endofpacket),
    .overflow             (overflow),
    .frame_width          (frame_width),
    .frame_height         (frame_height)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Downstream ready: 0 = held low, 1 = held high, 2 = toggle every cycle
  initial begin
    source_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       source_ready = 1'b0;
        1:       source_ready = 1'b1;
        default: source_ready = ~source_ready;
      endcase
    end
  end

  // Capture transferred beats and check stability across stalls
  always @(negedge clk) begin
    mon_beat = {source_data, source_startofpacket, source_endofpacket};
    if (prev_stall && !reset) begin
      check("stall_valid", 32'(source_valid), 32'd1);
      check("stall_beat", 32'(mon_beat), 32'(prev_beat));
    end
    if (source_valid && source_ready && !reset) rx_q.push_back(mon_beat);
    prev_stall = source_valid & ~source_ready & ~reset;
    prev_beat  = mon_beat;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1);
  end

  task automatic cyc(input logic dv, input logic [23:0] d, input logic hs, input logic vs);
    vid_datavalid = dv;
    vid_data      = d;
    vid_h_sync    = hs;
    vid_v_sync    = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) cyc(1'b0, 24'h0, 1'b0, 1'b1);
    idle(16);
  endtask

  task automatic send_frame(input int w, input int h, input logic [23:0] base);
    for (int l = 0; l < h; l++) begin
      cyc(1'b0, 24'h0, 1'b1, 1'b0);
      idle(2);
      for (int p = 0; p < w; p++) cyc(1'b1, base + 24'(l * w + p), 1'b0, 1'b0);
      idle(3);
    end
  endtask

  function automatic void exp_beat(input logic [23:0] d, input logic s, input logic e);
    exp_q.push_back({d, s, e});
  endfunction

  function automatic void exp_pixels(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) exp_beat(base + 24'(i), 1'b0, i == n - 1);
  endfunction

  function automatic void exp_header(input int w, input int h);
    logic [15:0] wv;
    logic [15:0] hv;
    wv = 16'(w);
    hv = 16'(h);
`ifdef CVRX_CTRL_PKT_EN
    if (wv != 0 && hv != 0) begin
      exp_beat(24'h00000F, 1'b1, 1'b0);
      exp_beat({4'h0, wv[7:4], 4'h0, wv[11:8], 4'h0, wv[15:12]}, 1'b0, 1'b0);
      exp_beat({4'h0, hv[11:8], 4'h0, hv[15:12], 4'h0, wv[3:0]}, 1'b0, 1'b0);
      exp_beat({4'h0, 4'h0, 4'h0, hv[3:0], 4'h0, hv[7:4]}, 1'b0, 1'b1);
    end
`endif
    exp_beat(24'h000000, 1'b1, 1'b0);
  endfunction

  task automatic compare_stream(input string tag);
    int budget;
    budget = 0;
    while (rx_q.size() < exp_q.size() && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_beat"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    vid_data = '0;
    vid_datavalid = 1'b0;
    vid_h_sync = 1'b0;
    vid_v_sync = 1'b0;
    @(posedge clk);
    #1;
    idle(3);
    reset = 1'b0;

    check("rst_valid", 32'(source_valid), 32'd0);
    check("rst_sop", 32'(source_startofpacket), 32'd0);
    check("rst_eop", 32'(source_endofpacket), 32'd0);
    check("rst_data", 32'(source_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_width", 32'(frame_width), 32'd0);
    check("rst_height", 32'(frame_height), 32'd0);

    // 4x3 frame, then a zero-pixel frame
    vsync_pulse();
    exp_header(0, 0);
    send_frame(4, 3, 24'h000001);
    exp_pixels(12, 24'h000001);
    vsync_pulse();
    exp_header(4, 3);
    compare_stream("frame4x3");
    check("width_4x3", 32'(frame_width), 32'd4);
    check("height_4x3", 32'(frame_height), 32'd3);

    vsync_pulse();
    exp_beat(24'h0, 1'b0, 1'b1);
    exp_header(0, 0);
    compare_stream("zero_frame");
    check("height_zero", 32'(frame_height), 32'd0);
    check("width_zero", 32'(frame_width), 32'd0);

    // Backpressure toggling every cycle
    ready_mode = 2;
    send_frame(4, 3, 24'h000010);
    exp_pixels(12, 24'h000010);
    vsync_pulse();
    exp_header(4, 3);
    compare_stream("toggle");
    ready_mode = 1;
    idle(2);

    // Reset in the middle of a frame
    ready_mode = 0;
    idle(1);
    cyc(1'b0, 24'h0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 5; i++) cyc(1'b1, 24'h000201 + 24'(i), 1'b0, 1'b0);
    idle(2);
    check("pre_reset_valid", 32'(source_valid), 32'd1);
    reset = 1'b1;
    cyc(1'b0, 24'h0, 1'b0, 1'b0);
    check("reset_flush_valid", 32'(source_valid), 32'd0);
    reset = 1'b0;
    ready_mode = 1;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 24'h000206 + 24'(i), 1'b0, 1'b0);
    idle(10);
    check("post_reset_quiet", 32'(rx_q.size()), 32'd0);
    check("post_reset_width", 32'(frame_width), 32'd0);

    // Overflow: ready held low across a 640-pixel line
    ready_mode = 0;
    idle(1);
    vsync_pulse();
    exp_header(0, 0);
    send_frame(640, 1, 24'h000100);
    exp_pixels(63, 24'h000100);
    check("overflow_set", 32'(overflow), 32'd1);
    ready_mode = 1;
    compare_stream("overflow");

    vsync_pulse();
    exp_header(640, 1);
    send_frame(4, 3, 24'h000300);
    exp_pixels(12, 24'h000300);
    vsync_pulse();
    exp_header(4, 3);
    compare_stream("after_overflow");
    check("width_after", 32'(frame_width), 32'd4);
    check("height_after", 32'(frame_height), 32'd3);
    check("overflow_sticky", 32'(overflow), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
